// File: rtl/dataset_writer.sv
// rtl/dataset_writer.sv - 128x10 labelled-sample capture memory with load/full/clear FSM.
// Optional per-label histogram output enabled by DATASET_WRITER_HIST_EN.
module dataset_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [7:0]  sample_data,
  input  logic [1:0]  sample_label,
  output logic        sample_ready,
  input  logic [6:0]  rd_addr,
  output logic [9:0]  rd_data,
  output logic [7:0]  count,
  output logic        done,
  output logic [1:0]  state
`ifdef DATASET_WRITER_HIST_EN
  ,
  output logic [31:0] label_hist
`endif
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b10;
  localparam logic [1:0] S_CLEAR = 2'b11;

  logic [1:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [6:0] sweep_q, sweep_d;

  logic [9:0] mem [0:127];
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [9:0] wr_data;
  logic       accept;
  logic       hist_clr;

  assign sample_ready = (state_q == S_LOAD) && !count_q[7];
  assign done         = (state_q == S_FULL);
  assign state        = state_q;
  assign count        = count_q;
  assign rd_data      = mem[rd_addr];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sweep_d  = sweep_q;
    wr_en    = 1'b0;
    wr_addr  = count_q[6:0];
    wr_data  = {sample_label, sample_data};
    accept   = 1'b0;
    hist_clr = 1'b0;
    case (state_q)
      S_IDLE, S_FULL: begin
        if (clear) begin
          state_d  = S_CLEAR;
          sweep_d  = 7'd0;
          hist_clr = 1'b1;
        end else if (start) begin
          state_d  = S_LOAD;
          count_d  = 8'd0;
          hist_clr = 1'b1;
        end
      end
      S_LOAD: begin
        // An abort takes priority over any sample offered on the same edge.
        if (clear) begin
          state_d  = S_CLEAR;
          sweep_d  = 7'd0;
          hist_clr = 1'b1;
        end else begin
          if (sample_valid && sample_ready) begin
            accept  = 1'b1;
            wr_en   = 1'b1;
            count_d = count_q + 8'd1;
          end
          if (finish || (accept && (count_q == 8'd127))) begin
            state_d = S_FULL;
          end
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = 10'h000;
        sweep_d = sweep_q + 7'd1;
        if (sweep_q == 7'd127) begin
          state_d = S_IDLE;
          count_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= 8'd0;
      sweep_q <= 7'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sweep_q <= sweep_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef DATASET_WRITER_HIST_EN
  logic [3:0][7:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (hist_clr) begin
      hist_d = '0;
    end else if (accept) begin
      hist_d[sample_label] = hist_q[sample_label] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign label_hist = hist_q;
`else
  logic unused_hist;
  assign unused_hist = accept ^ hist_clr;
`endif

endmodule

// File: tb/tb_dataset_writer.sv
// tb/tb_dataset_writer.sv - directed table-driven bench for dataset_writer.
// Histogram checks are built only when DATASET_WRITER_HIST_EN is defined.
module tb_dataset_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, finish = 1'b0, clear = 1'b0, sample_valid = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic [1:0] sample_label = 2'b00;
  logic       sample_ready;
  logic [6:0] rd_addr = 7'd0;
  logic [9:0] rd_data;
  logic [7:0] count;
  logic       done;
  logic [1:0] state;
`ifdef DATASET_WRITER_HIST_EN
  logic [31:0] label_hist;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dataset_writer dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .clear(clear),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_label(sample_label),
    .sample_ready(sample_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .done(done), .state(state)
`ifdef DATASET_WRITER_HIST_EN
    , .label_hist(label_hist)
`endif
  );

  typedef struct {
    logic       st, fi, cl, v;
    logic [7:0] d;
    logic [1:0] l;
    logic [6:0] ra;
    logic       chk_rd;
    logic [1:0] e_state;
    logic [7:0] e_count;
    logic       e_ready, e_done;
    logic [9:0] e_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; finish = 0; clear = 0; sample_valid = 0;
    sample_data = 8'h00; sample_label = 2'b00;
  endtask

  task automatic wait_clear(input string name);
    int cyc = 0;
    while (state == 2'b11 && cyc < 300) begin
      cyc++;
      start = (cyc == 50);
      step();
    end
    start = 0;
    chk({name, "_cycles"}, cyc, 128);
    chk({name, "_state"}, state, 2'b00);
    chk({name, "_count"}, count, 0);
  endtask

  initial begin
    int acc;
    int bad;

    vecs[0]  = '{1,0,0,0,8'h00,2'd0,7'd0,0, 2'b01,8'd0,1,0,10'h000};
    vecs[1]  = '{0,0,0,1,8'h3A,2'd1,7'd0,1, 2'b01,8'd1,1,0,10'h13A};
    vecs[2]  = '{0,0,0,1,8'hF0,2'd2,7'd1,1, 2'b01,8'd2,1,0,10'h2F0};
    vecs[3]  = '{0,0,0,1,8'h00,2'd0,7'd2,1, 2'b01,8'd3,1,0,10'h000};
    vecs[4]  = '{0,1,0,0,8'h00,2'd0,7'd1,1, 2'b10,8'd3,0,1,10'h2F0};
    vecs[5]  = '{0,0,0,1,8'h55,2'd3,7'd0,1, 2'b10,8'd3,0,1,10'h13A};
    vecs[6]  = '{1,0,0,0,8'h00,2'd0,7'd1,1, 2'b01,8'd0,1,0,10'h2F0};
    vecs[7]  = '{0,0,0,1,8'h11,2'd0,7'd0,1, 2'b01,8'd1,1,0,10'h011};
    vecs[8]  = '{0,0,0,1,8'h22,2'd1,7'd1,1, 2'b01,8'd2,1,0,10'h122};
    vecs[9]  = '{0,0,0,1,8'h33,2'd2,7'd2,1, 2'b01,8'd3,1,0,10'h233};
    vecs[10] = '{0,0,0,1,8'h44,2'd3,7'd3,1, 2'b01,8'd4,1,0,10'h344};
    vecs[11] = '{0,1,0,1,8'h55,2'd1,7'd4,1, 2'b10,8'd5,0,1,10'h155};
    vecs[12] = '{1,0,0,0,8'h00,2'd0,7'd4,1, 2'b01,8'd0,1,0,10'h155};
    vecs[13] = '{0,0,1,1,8'hFF,2'd3,7'd0,1, 2'b11,8'd0,0,0,10'h011};

    // Reset state while clock runs
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1;
    #1;

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].st; finish = vecs[i].fi; clear = vecs[i].cl;
      sample_valid = vecs[i].v; sample_data = vecs[i].d; sample_label = vecs[i].l;
      rd_addr = vecs[i].ra;
      step();
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_ready", i), sample_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), rd_data, vecs[i].e_rd);
    end
    idle_inputs();

    // Sweep from aborted load; a start mid-sweep must be ignored
    wait_clear("clr1");
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      rd_addr = a[6:0];
      #1;
      if (rd_data !== 10'h000) bad++;
    end
    chk("clr1_nonzero_words", bad, 0);

    // clear beats start in IDLE
    start = 1; clear = 1;
    step();
    idle_inputs();
    chk("idle_clr_prio", state, 2'b11);
    wait_clear("clr2");

    // 130 valid cycles: exactly 128 accepted
    start = 1;
    step();
    start = 0;
    acc = 0;
    for (int i = 0; i < 130; i++) begin
      sample_valid = 1; sample_data = i[7:0]; sample_label = i[1:0];
      if (sample_ready) acc++;
      step();
      if (i == 127) chk("full_ready_after_128", sample_ready, 0);
    end
    idle_inputs();
    chk("full_accepted", acc, 128);
    chk("full_count", count, 128);
    chk("full_done", done, 1);
    chk("full_state", state, 2'b10);
    rd_addr = 7'd127; #1;
    chk("full_word127", rd_data, 10'h37F);
    rd_addr = 7'd5; #1;
    chk("full_word5", rd_data, 10'h105);

    // Reset mid-load after 10 samples
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1; sample_data = 8'hA0 + i[7:0]; sample_label = i[1:0];
      step();
    end
    idle_inputs();
    chk("mid_count", count, 10);
    #2 rst = 0;
    #1;
    chk("mid_rst_state", state, 2'b00);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", sample_ready, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1;
    step();
    step();
    bad = 0;
    for (int a = 0; a < 10; a++) begin
      rd_addr = a[6:0];
      #1;
      if (rd_data !== {a[1:0], 8'hA0 + a[7:0]}) bad++;
    end
    chk("mid_words_kept", bad, 0);
    rd_addr = 7'd10; #1;
    chk("mid_word10_old", rd_data, 10'h20A);

`ifdef DATASET_WRITER_HIST_EN
    begin
      logic [1:0] labs [6];
      labs = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
      start = 1;
      step();
      start = 0;
      chk("hist_zero_on_start", label_hist, 32'h0);
      for (int i = 0; i < 6; i++) begin
        sample_valid = 1; sample_data = 8'h10 + i[7:0]; sample_label = labs[i];
        step();
      end
      idle_inputs();
      chk("hist_value", label_hist, 32'h03000201);
      clear = 1;
      step();
      clear = 0;
      chk("hist_zero_on_clear", label_hist, 32'h0);
      wait_clear("clr3");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
